// File: rtl/perf_pkg.sv
// ============================================================================
// Module   : perf_pkg
// Brief    : Shared types and constants for the performance event counter bank.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package perf_pkg;

  typedef enum logic [0:0] {
    PERF_RUN    = 1'b0,
    PERF_HALTED = 1'b1
  } perfState_t;

  // Default event channel mapping
  localparam int EVT_INST = 0;
  localparam int EVT_DREQ = 1;
  localparam int EVT_DHIT = 2;
  localparam int EVT_IREQ = 3;
  localparam int EVT_IHIT = 4;

  localparam int DEF_NUM_EVT  = 5;
  localparam int DEF_CNT_W    = 32;
  localparam int DEF_SAT_MODE = 0;

endpackage

`default_nettype wire

// File: rtl/perf_cnt_cell.sv
// ============================================================================
// Module   : perf_cnt_cell
// Brief    : Single event counter with wrap/saturate overflow and sticky flag.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module perf_cnt_cell
  import perf_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int SAT_MODE = DEF_SAT_MODE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] value,
  output logic             ovf
);

  logic [CNT_W-1:0] r_value;
  logic             r_ovf;
  logic             w_allOnes;

  assign w_allOnes = &r_value;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= '0;
      r_ovf   <= 1'b0;
    end else if (clr) begin
      r_value <= '0;
      r_ovf   <= 1'b0;
    end else if (inc) begin
      if (w_allOnes) begin
        r_ovf <= 1'b1;
        // Saturating mode simply holds the all-ones value
        if (SAT_MODE == 0) begin
          r_value <= '0;
        end
      end else begin
        r_value <= r_value + CNT_W'(1);
      end
    end
  end

  assign value = r_value;
  assign ovf   = r_ovf;

endmodule

`default_nettype wire

// File: rtl/perf_event_counters.sv
// ============================================================================
// Module   : perf_event_counters
// Brief    : Event counter bank with halt freeze, clear and pipelined readback.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module perf_event_counters
  import perf_pkg::*;
#(
  parameter int NUM_EVT  = DEF_NUM_EVT,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int SAT_MODE = DEF_SAT_MODE,
  parameter int IDX_W    = $clog2(NUM_EVT + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic               halt_i,
  input  logic               clr_i,
  input  logic               rd_req_i,
  input  logic [IDX_W-1:0]   rd_idx_i,
  output logic               rd_valid_o,
  output logic [CNT_W-1:0]   rd_data_o,
  output logic               rd_err_o,
  output logic [NUM_EVT:0]   ovf_o,
  output logic               halted_o
);

  localparam int c_NUM_CNT = NUM_EVT + 1;

  perfState_t       r_state;
  perfState_t       w_nextState;
  logic             w_countEn;
  logic [NUM_EVT:0] w_inc;
  logic [NUM_EVT:0] w_ovf;
  logic [CNT_W-1:0] w_cntVal [c_NUM_CNT];
  logic [CNT_W-1:0] w_rdData;
  logic             w_rdErr;
  logic             r_rdValid;
  logic [CNT_W-1:0] r_rdData;
  logic             r_rdErr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= PERF_RUN;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    if (clr_i) begin
      w_nextState = PERF_RUN;
    end else if ((r_state == PERF_RUN) && halt_i) begin
      w_nextState = PERF_HALTED;
    end
  end

  // The halting cycle still counts; the clear cycle never does
  assign w_countEn = en_i & ~clr_i & (r_state == PERF_RUN);
  assign w_inc     = {w_countEn, evt_i & {NUM_EVT{w_countEn}}};

  generate
    for (genvar gi = 0; gi < c_NUM_CNT; gi++) begin : g_cell
      perf_cnt_cell #(
        .CNT_W    (CNT_W),
        .SAT_MODE (SAT_MODE)
      ) u_cell (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_inc[gi]),
        .clr   (clr_i),
        .value (w_cntVal[gi]),
        .ovf   (w_ovf[gi])
      );
    end
  endgenerate

  always_comb begin
    w_rdData = '0;
    w_rdErr  = 1'b1;
    for (int i = 0; i < c_NUM_CNT; i++) begin
      if (rd_idx_i == IDX_W'(i)) begin
        w_rdData = w_cntVal[i];
        w_rdErr  = 1'b0;
      end
    end
  end

  // Data and error hold between requests; only the valid strobe pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdValid <= 1'b0;
      r_rdData  <= '0;
      r_rdErr   <= 1'b0;
    end else begin
      r_rdValid <= rd_req_i;
      if (rd_req_i) begin
        r_rdData <= w_rdData;
        r_rdErr  <= w_rdErr;
      end
    end
  end

  assign rd_valid_o = r_rdValid;
  assign rd_data_o  = r_rdData;
  assign rd_err_o   = r_rdErr;
  assign ovf_o      = w_ovf;
  assign halted_o   = (r_state == PERF_HALTED);

endmodule

`default_nettype wire

// File: tb/tb_perf_event_counters.sv
// ============================================================================
// Module   : tb_perf_event_counters
// Brief    : Scoreboard bench driving a wrapping and a saturating 8-bit bank.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_perf_event_counters;

  localparam int NE = 5;
  localparam int W  = 8;
  localparam int IW = 3;

  typedef struct {
    logic [W-1:0] dA;
    logic [W-1:0] dB;
    logic         err;
  } rdExp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en_i;
  logic [NE-1:0] evt_i;
  logic          halt_i;
  logic          clr_i;
  logic          rd_req_i;
  logic [IW-1:0] rd_idx_i;

  logic          rdValidA, rdErrA, haltedA;
  logic [W-1:0]  rdDataA;
  logic [NE:0]   ovfA;
  logic          rdValidB, rdErrB, haltedB;
  logic [W-1:0]  rdDataB;
  logic [NE:0]   ovfB;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mCnt [2][NE+1];
  logic         mOvf [2][NE+1];
  logic         mHalt;
  rdExp_t       expQ [$];

  always #5 clk = ~clk;

  perf_event_counters #(.NUM_EVT(NE), .CNT_W(W), .SAT_MODE(0)) u_dutWrap (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .evt_i(evt_i), .halt_i(halt_i),
    .clr_i(clr_i), .rd_req_i(rd_req_i), .rd_idx_i(rd_idx_i),
    .rd_valid_o(rdValidA), .rd_data_o(rdDataA), .rd_err_o(rdErrA),
    .ovf_o(ovfA), .halted_o(haltedA)
  );

  perf_event_counters #(.NUM_EVT(NE), .CNT_W(W), .SAT_MODE(1)) u_dutSat (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .evt_i(evt_i), .halt_i(halt_i),
    .clr_i(clr_i), .rd_req_i(rd_req_i), .rd_idx_i(rd_idx_i),
    .rd_valid_o(rdValidB), .rd_data_o(rdDataB), .rd_err_o(rdErrB),
    .ovf_o(ovfB), .halted_o(haltedB)
  );

  task automatic chkVal(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i <= NE; i++) begin
        mCnt[k][i] = '0;
        mOvf[k][i] = 1'b0;
      end
    end
    mHalt = 1'b0;
  endtask

  task automatic modelStep();
    logic inc;
    if (clr_i) begin
      modelReset();
    end else if (!mHalt) begin
      if (en_i) begin
        for (int k = 0; k < 2; k++) begin
          for (int i = 0; i <= NE; i++) begin
            inc = (i == NE) ? 1'b1 : evt_i[i];
            if (inc) begin
              if (mCnt[k][i] == {W{1'b1}}) begin
                mOvf[k][i] = 1'b1;
                mCnt[k][i] = (k == 1) ? {W{1'b1}} : '0;
              end else begin
                mCnt[k][i] = mCnt[k][i] + W'(1);
              end
            end
          end
        end
      end
      if (halt_i) mHalt = 1'b1;
    end
  endtask

  function automatic logic [NE:0] ovfVec(input int k);
    logic [NE:0] v;
    for (int i = 0; i <= NE; i++) v[i] = mOvf[k][i];
    return v;
  endfunction

  // One clock: record read expectation, advance model, compare after the edge
  task automatic tick();
    rdExp_t e;
    if (rd_req_i) begin
      e.err = (rd_idx_i > IW'(NE));
      e.dA  = e.err ? '0 : mCnt[0][rd_idx_i];
      e.dB  = e.err ? '0 : mCnt[1][rd_idx_i];
      expQ.push_back(e);
    end
    modelStep();
    @(posedge clk);
    #1;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      chkVal("rdValidWrap", rdValidA, 1);
      chkVal("rdValidSat",  rdValidB, 1);
      chkVal("rdDataWrap",  rdDataA, e.dA);
      chkVal("rdDataSat",   rdDataB, e.dB);
      chkVal("rdErrWrap",   rdErrA, e.err);
      chkVal("rdErrSat",    rdErrB, e.err);
    end else begin
      chkVal("rdIdleWrap", rdValidA, 0);
      chkVal("rdIdleSat",  rdValidB, 0);
    end
    chkVal("ovfWrap",    ovfA, ovfVec(0));
    chkVal("ovfSat",     ovfB, ovfVec(1));
    chkVal("haltedWrap", haltedA, mHalt);
    chkVal("haltedSat",  haltedB, mHalt);
  endtask

  task automatic readOne(input int idx);
    rd_req_i = 1'b1;
    rd_idx_i = IW'(idx);
    tick();
    rd_req_i = 1'b0;
  endtask

  task automatic chkAllZero(input string tag);
    chkVal({tag, "Valid"},  {rdValidA, rdValidB}, 0);
    chkVal({tag, "Data"},   {rdDataA, rdDataB}, 0);
    chkVal({tag, "Err"},    {rdErrA, rdErrB}, 0);
    chkVal({tag, "Ovf"},    {ovfA, ovfB}, 0);
    chkVal({tag, "Halted"}, {haltedA, haltedB}, 0);
  endtask

  initial begin
    rst_n = 1'b0; en_i = 1'b0; evt_i = '0; halt_i = 1'b0;
    clr_i = 1'b0; rd_req_i = 1'b0; rd_idx_i = '0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    chkAllZero("reset");

    // Reset and count
    @(negedge clk);
    rst_n = 1'b1;
    en_i  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      evt_i    = '0;
      evt_i[2] = (i % 3 == 0);
      tick();
    end
    evt_i = '0;
    readOne(2);
    chkVal("evt2Count", rdDataA, 7);
    readOne(5);
    chkVal("cycleCount", rdDataA, 21);

    // Halt freeze: the halting cycle's event is kept
    evt_i  = 5'b00001;
    halt_i = 1'b1;
    tick();
    halt_i = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    evt_i = '0;
    readOne(0);
    chkVal("haltFrozen0", rdDataA, 1);
    readOne(5);

    // Overflow: 257 events on channel 3 after a clear
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    evt_i = 5'b01000;
    for (int i = 0; i < 257; i++) tick();
    evt_i = '0;
    readOne(3);
    chkVal("wrapVal", rdDataA, 1);
    chkVal("satVal",  rdDataB, 255);
    chkVal("wrapOvf3", ovfA[3], 1);
    chkVal("satOvf3",  ovfB[3], 1);

    // Clear priority over halt, with a same-cycle read and event
    evt_i = 5'b00010;
    repeat (3) tick();
    clr_i = 1'b1; halt_i = 1'b1; rd_req_i = 1'b1; rd_idx_i = 3'd1;
    tick();
    chkVal("preClearRead", rdDataA, 3);
    clr_i = 1'b0; halt_i = 1'b0; rd_req_i = 1'b0; evt_i = '0;
    chkVal("ovfAfterClr", {ovfA, ovfB}, 0);
    chkVal("runAfterClr", {haltedA, haltedB}, 0);
    readOne(1);
    chkVal("cnt1AfterClr", rdDataA, 0);

    // Out-of-range indices, then back-to-back reads 0..5
    readOne(7);
    chkVal("badIdxErr",  rdErrA, 1);
    chkVal("badIdxData", rdDataA, 0);
    readOne(6);
    evt_i    = 5'b10101;
    rd_req_i = 1'b1;
    for (int i = 0; i <= NE; i++) begin
      rd_idx_i = IW'(i);
      tick();
    end
    rd_req_i = 1'b0;
    evt_i    = '0;
    tick();

    // Asynchronous reset between edges
    halt_i = 1'b1;
    tick();
    halt_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chkAllZero("asyncRst");
    modelReset();
    expQ.delete();
    @(negedge clk);
    rst_n = 1'b1;
    evt_i = 5'b00100;
    repeat (2) tick();
    evt_i = '0;
    readOne(2);
    chkVal("cnt2AfterRst", rdDataA, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/perf_event_counters.md
# perf_event_counters

Synthesizable, parameterised bank of hardware event counters that sits beside the processor core (`proc`) and counts retired instructions, I/D-cache requests and hits, and cycles. It replaces bench-only counting, so performance numbers are available from the silicon model. Counting freezes on processor halt, and counters can be read back one per cycle through a pipelined request/response port. Each counter supports wrap or saturate overflow with sticky overflow flags.

## Interface
- `NUM_EVT`, default 5: number of external event channels. Default mapping: 0 = instruction retired, 1 = DCacheReq, 2 = DCacheHit, 3 = ICacheReq, 4 = ICacheHit.
- `CNT_W`, default 32: counter width, legal range 8..64.
- `SAT_MODE`, default 0: overflow mode. 0 = wrap to 0; 1 = saturate at all-ones.
- `IDX_W`, default `$clog2(NUM_EVT+1)`: read index width. Derived; do not override.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en_i`  in  1  global count enable.
- `evt_i`  in  NUM_EVT  per-channel event pulse; each set bit adds 1 in that cycle.
- `halt_i`  in  1  processor halt indication.
- `clr_i`  in  1  synchronous clear of all counters and flags.
- `rd_req_i`  in  1  read request.
- `rd_idx_i`  in  IDX_W  counter select. 0..NUM_EVT-1 select events; NUM_EVT selects the cycle counter.
- `rd_valid_o`  out  1  read response valid.
- `rd_data_o`  out  CNT_W  read response data.
- `rd_err_o`  out  1  index was out of range.
- `ovf_o`  out  NUM_EVT+1  sticky overflow flag per counter; bit NUM_EVT is the cycle counter.
- `halted_o`  out  1  bank is frozen after halt.

## Operation
- The bank has NUM_EVT+1 counters: the event counters plus an internal cycle counter at index NUM_EVT.
- There are two states, RUN and HALTED. Reset and clear both enter RUN.
- In RUN:
  - The cycle counter increments each cycle while `en_i` = 1.
  - Counter i increments when `evt_i[i] & en_i`.
- In RUN, when `halt_i` = 1:
  - Events and the cycle in that same cycle are still counted.
  - The state moves to HALTED on the next edge, and `halted_o` goes to 1.
- In HALTED, nothing counts and `halt_i` is ignored. Only `clr_i` or reset leaves HALTED.
- `clr_i` has the highest priority. On the next edge all counters go to 0, all `ovf_o` bits go to 0, state goes to RUN and `halted_o` goes to 0. Events in the clear cycle are discarded. If `clr_i` and `halt_i` are both 1, clear wins.
- Overflow, for an increment at all-ones:
  - SAT_MODE=0: the counter becomes 0 and its `ovf` bit sets.
  - SAT_MODE=1: the counter holds at all-ones and its `ovf` bit sets.
  - `ovf` bits stay set until clear or reset.
- Reads:
  - `rd_req_i` in cycle N returns in cycle N+1 with `rd_valid_o` = 1.
  - `rd_data_o` is the register value at the start of cycle N, i.e. before that cycle's increment or clear.
  - `rd_idx_i` > NUM_EVT returns `rd_data_o` = 0 and `rd_err_o` = 1.
  - Reads work in both RUN and HALTED.
- Width rules:
  - Every increment is +1, modulo 2^CNT_W or saturating.
  - There is no carry between counters.

## Timing
- Reset values: all counters 0, `ovf_o` 0, `rd_valid_o` 0, `rd_data_o` 0, `rd_err_o` 0, `halted_o` 0, state RUN.
- All outputs are registered, with no combinational path from inputs to outputs.
- Read latency is 1 cycle and throughput is 1 read per cycle. No backpressure: `rd_valid_o` is a one-cycle pulse for each request.
- `rd_valid_o` = 0 in any cycle that follows a cycle without a request. `rd_data_o` and `rd_err_o` hold their last values.
- Halt-to-freeze latency is 1 edge. Counters read in the cycle after `halt_i` show the final values.
- If `rst_n` asserts mid-operation, all state clears immediately and asynchronously. Release is sampled synchronously at the first edge with `rst_n` = 1.

## Structure
- Package `perf_pkg` holds:
  - the state enum (`PERF_RUN`, `PERF_HALTED`);
  - event index constants (`EVT_INST`, `EVT_DREQ`, `EVT_DHIT`, `EVT_IREQ`, `EVT_IHIT`);
  - the default widths.
- One sub-module, `perf_cnt_cell`: a single CNT_W counter with inputs inc, clr and SAT_MODE, and outputs value and sticky ovf. It is instantiated NUM_EVT+1 times with a generate loop.
- The top level holds the FSM, the read mux and the read pipeline register.

## Test plan
- Reset and count: release `rst_n`, hold `en_i` = 1, pulse `evt_i[2]` on 7 cycles out of 20, then read index 2 and index 5 → data 7, and the cycle count equals the number of elapsed enabled cycles. `rd_valid_o` is 1 exactly one cycle after each request.
- Halt freeze: `halt_i` in a cycle where `evt_i[0]` = 1 → that event is counted and `halted_o` = 1 next cycle. 10 further pulses leave counter 0 unchanged, and reads still return values.
- Overflow with CNT_W=8: apply 257 events.
  - SAT_MODE=0 → value 1 and `ovf_o[i]` = 1.
  - SAT_MODE=1 → value 255 and `ovf_o[i]` = 1.
- Clear priority: `clr_i`, `halt_i`, `rd_req_i` on index 1 and `evt_i[1]` in the same cycle → read returns the pre-clear value; next cycle counter 1 = 0, state RUN, `ovf_o` = 0.
- Bad index with NUM_EVT=5: read index 7 → `rd_err_o` = 1 and `rd_data_o` = 0. Back-to-back reads of indices 0..5 → six consecutive valid responses in order.
- Async reset mid-count: drop `rst_n` between edges → all outputs are 0 before the next edge.
